// File: rtl/mux2to1_rr_feeder_if.sv
// Handshake and mux-facing bundle for the two-channel round-robin feeder.
// The feeder itself connects through the slave modport; the environment uses master.
interface mux2to1_rr_feeder_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             sel;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, in0, in1, sel, out_valid, cnt0, cnt1
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, in0, in1, sel, out_valid, cnt0, cnt1
  );
endinterface

// File: rtl/mux2to1_rr_feeder.sv
// Two-channel round-robin feeder: one-entry buffers per channel, a registered
// mux select that alternates when both channels are pending, and grant counters.
module mux2to1_rr_feeder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mux2to1_rr_feeder_if.slave  bus
);
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic             v0_q, v0_d;
  logic             v1_q, v1_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic load0, load1, out_valid, xfer, other_pending;

  always_comb begin
    load0         = bus.a_valid & ~v0_q;
    load1         = bus.b_valid & ~v1_q;
    out_valid     = sel_q ? v1_q : v0_q;
    xfer          = out_valid & bus.out_ready;
    other_pending = sel_q ? (v0_q | load0) : (v1_q | load1);

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    sel_d  = sel_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;

    if (load0) begin
      v0_d   = 1'b1;
      buf0_d = bus.a_data;
    end
    if (load1) begin
      v1_d   = 1'b1;
      buf1_d = bus.b_data;
    end

    // A load and a drain never hit the same buffer: loads require it empty.
    if (xfer) begin
      if (sel_q) begin
        v1_d   = 1'b0;
        cnt1_d = cnt1_q + CNT_W'(1);
      end else begin
        v0_d   = 1'b0;
        cnt0_d = cnt0_q + CNT_W'(1);
      end
    end

    // Hold while a stalled word is presented; otherwise move to a pending peer.
    if ((!out_valid || xfer) && other_pending) begin
      sel_d = ~sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf0_q <= '0;
      buf1_q <= '0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      sel_q  <= 1'b0;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      sel_q  <= sel_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign bus.a_ready   = ~v0_q;
  assign bus.b_ready   = ~v1_q;
  assign bus.in0       = buf0_q;
  assign bus.in1       = buf1_q;
  assign bus.sel       = sel_q;
  assign bus.out_valid = out_valid;
  assign bus.cnt0      = cnt0_q;
  assign bus.cnt1      = cnt1_q;
endmodule

// File: tb/tb_mux2to1_rr_feeder.sv
// Bench for mux2to1_rr_feeder: directed vector table, corner sequences and a
// randomized run against a channel-level reference model.
module tb_mux2to1_rr_feeder;
  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  mux2to1_rr_feeder_if #(.WIDTH(8), .CNT_W(8)) busMain ();
  mux2to1_rr_feeder_if #(.WIDTH(8), .CNT_W(2)) busSmall ();

  // The narrow-counter instance mirrors the main stimulus to exercise wrap.
  assign busSmall.a_valid   = busMain.a_valid;
  assign busSmall.a_data    = busMain.a_data;
  assign busSmall.b_valid   = busMain.b_valid;
  assign busSmall.b_data    = busMain.b_data;
  assign busSmall.out_ready = busMain.out_ready;

  mux2to1_rr_feeder #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (busMain)
  );

  mux2to1_rr_feeder #(.WIDTH(8), .CNT_W(2)) dutSmall (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (busSmall)
  );

  int testsRun  = 0;
  int failCount = 0;

  int         mOcc[2];
  logic [7:0] mBuf[2];
  int         mSel;
  int         mCnt[2];
  logic [7:0] dutDelivered[$];

  typedef struct {
    logic       rn;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic       eSel;
    logic       eOv;
    logic [7:0] eIn0;
    logic [7:0] eIn1;
    logic [7:0] eCnt0;
    logic [7:0] eCnt1;
    logic       eAr;
    logic       eBr;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Reference: each channel is a one-slot holding place; the turn passes to the
  // other channel whenever the current one has nothing stalled and the other waits.
  task automatic modelStep(input logic rn, input logic av, input logic [7:0] ad,
                           input logic bv, input logic [7:0] bd, input logic ordy);
    int cur, oth;
    bit acc[2];
    bit hadWord, othPend;
    if (!rn) begin
      mOcc = '{0, 0};
      mBuf = '{8'h00, 8'h00};
      mSel = 0;
      mCnt = '{0, 0};
      return;
    end
    cur     = mSel;
    oth     = 1 - mSel;
    acc[0]  = av && (mOcc[0] == 0);
    acc[1]  = bv && (mOcc[1] == 0);
    hadWord = (mOcc[cur] != 0);
    othPend = (mOcc[oth] != 0) || acc[oth];
    if (hadWord && ordy) begin
      mOcc[cur] = 0;
      mCnt[cur] = (mCnt[cur] + 1) % 256;
    end
    if (acc[0]) begin
      mOcc[0] = 1;
      mBuf[0] = ad;
    end
    if (acc[1]) begin
      mOcc[1] = 1;
      mBuf[1] = bd;
    end
    if (!(hadWord && !ordy) && othPend) mSel = oth;
  endtask

  task automatic compareModel();
    checkOutput("model.sel", busMain.sel, 32'(mSel));
    checkOutput("model.out_valid", busMain.out_valid, 32'(mOcc[mSel] != 0));
    checkOutput("model.in0", busMain.in0, mBuf[0]);
    checkOutput("model.in1", busMain.in1, mBuf[1]);
    checkOutput("model.a_ready", busMain.a_ready, 32'(mOcc[0] == 0));
    checkOutput("model.b_ready", busMain.b_ready, 32'(mOcc[1] == 0));
    checkOutput("model.cnt0", busMain.cnt0, 32'(mCnt[0]));
    checkOutput("model.cnt1", busMain.cnt1, 32'(mCnt[1]));
    checkOutput("model.smallCnt0", busSmall.cnt0, 32'(mCnt[0] % 4));
    checkOutput("model.smallCnt1", busSmall.cnt1, 32'(mCnt[1] % 4));
  endtask

  task automatic step();
    if (rstN && busMain.out_valid && busMain.out_ready)
      dutDelivered.push_back(busMain.sel ? busMain.in1 : busMain.in0);
    @(posedge clk);
    modelStep(rstN, busMain.a_valid, busMain.a_data, busMain.b_valid, busMain.b_data, busMain.out_ready);
    #1;
    compareModel();
  endtask

  task automatic applyStimulus(input logic rn, input logic av, input logic [7:0] ad,
                               input logic bv, input logic [7:0] bd, input logic ordy);
    rstN              = rn;
    busMain.a_valid   = av;
    busMain.a_data    = ad;
    busMain.b_valid   = bv;
    busMain.b_data    = bd;
    busMain.out_ready = ordy;
    step();
  endtask

  initial begin
    logic [7:0] expOrder[8];
    int         wrapSeq[5];
    int         ia, ib, k, cyc;
    bit         aHs, bHs, xferNow;

    rstN              = 1'b0;
    busMain.a_valid   = 1'b0;
    busMain.a_data    = 8'h00;
    busMain.b_valid   = 1'b0;
    busMain.b_data    = 8'h00;
    busMain.out_ready = 1'b0;

    // rn av ad bv bd ordy | sel ov in0 in1 cnt0 cnt1 ar br
    vecs[0]  = '{1'b0, 1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 8'd0, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 8'h55, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'd0, 8'd0, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 8'h00, 8'h11, 8'd0, 8'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h11, 8'd0, 8'd1, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h11, 8'd0, 8'd1, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hB5, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hB5, 8'd0, 8'd1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hB6, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hB5, 8'd0, 8'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hB6, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hB5, 8'd0, 8'd1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'hB6, 1'b0, 1'b0, 1'b1, 8'h3C, 8'hB5, 8'd0, 8'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hB5, 8'd1, 8'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 8'hB5, 8'd1, 8'd2, 1'b1, 1'b1};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rn, vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
      checkOutput($sformatf("vec%0d.sel", i), busMain.sel, vecs[i].eSel);
      checkOutput($sformatf("vec%0d.out_valid", i), busMain.out_valid, vecs[i].eOv);
      checkOutput($sformatf("vec%0d.in0", i), busMain.in0, vecs[i].eIn0);
      checkOutput($sformatf("vec%0d.in1", i), busMain.in1, vecs[i].eIn1);
      checkOutput($sformatf("vec%0d.cnt0", i), busMain.cnt0, vecs[i].eCnt0);
      checkOutput($sformatf("vec%0d.cnt1", i), busMain.cnt1, vecs[i].eCnt1);
      checkOutput($sformatf("vec%0d.a_ready", i), busMain.a_ready, vecs[i].eAr);
      checkOutput($sformatf("vec%0d.b_ready", i), busMain.b_ready, vecs[i].eBr);
    end

    // Alternation: channel 0 starts one cycle ahead so it wins the first grant.
    expOrder = '{8'hA0, 8'hB0, 8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3};
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    dutDelivered.delete();
    ia = 0;
    ib = 0;
    cyc = 0;
    while (dutDelivered.size() < 8 && cyc < 40) begin
      rstN              = 1'b1;
      busMain.a_valid   = 1'b1;
      busMain.a_data    = 8'hA0 + 8'(ia);
      busMain.b_valid   = (cyc >= 1);
      busMain.b_data    = 8'hB0 + 8'(ib);
      busMain.out_ready = 1'b1;
      aHs = busMain.a_valid && busMain.a_ready;
      bHs = busMain.b_valid && busMain.b_ready;
      step();
      if (aHs) ia++;
      if (bHs) ib++;
      cyc++;
    end
    checkOutput("alt.transferCount", 32'(dutDelivered.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < dutDelivered.size())
        checkOutput($sformatf("alt.word%0d", i), dutDelivered[i], expOrder[i]);
    end
    checkOutput("alt.cnt0", busMain.cnt0, 32'd4);
    checkOutput("alt.cnt1", busMain.cnt1, 32'd4);

    // Counter wrap on the 2-bit instance, channel 0 only.
    wrapSeq = '{1, 2, 3, 0, 1};
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    k = 0;
    cyc = 0;
    while (k < 5 && cyc < 30) begin
      rstN              = 1'b1;
      busMain.a_valid   = 1'b1;
      busMain.a_data    = 8'($urandom_range(0, 255));
      busMain.b_valid   = 1'b0;
      busMain.out_ready = 1'b1;
      xferNow = busMain.out_valid && busMain.out_ready;
      step();
      checkOutput($sformatf("wrap.sel.c%0d", cyc), busSmall.sel, 32'd0);
      if (xferNow) begin
        checkOutput($sformatf("wrap.cnt0.k%0d", k), busSmall.cnt0, 32'(wrapSeq[k]));
        k++;
      end
      cyc++;
    end
    checkOutput("wrap.transferCount", 32'(k), 32'd5);

    // Reset while both buffers are full and a transfer is being offered.
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b1, 8'h88, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    checkOutput("midrst.prefill.a_ready", busMain.a_ready, 32'd0);
    checkOutput("midrst.prefill.b_ready", busMain.b_ready, 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("midrst.cnt0", busMain.cnt0, 32'd0);
    checkOutput("midrst.cnt1", busMain.cnt1, 32'd0);
    checkOutput("midrst.sel", busMain.sel, 32'd0);
    checkOutput("midrst.in0", busMain.in0, 32'd0);
    checkOutput("midrst.in1", busMain.in1, 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("midrst.out_valid", busMain.out_valid, 32'd0);
    checkOutput("midrst.a_ready", busMain.a_ready, 32'd1);
    checkOutput("midrst.b_ready", busMain.b_ready, 32'd1);

    // Randomized traffic with occasional resets, checked against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
